// File: rtl/slave_io_pkg.sv
// Shared types and helpers for the slave_io register bank family.
// Register kinds, bank limits, and the byte-lane merge used on writes.
package slave_io_pkg;

    typedef enum logic [1:0] {
        RW,
        RO,
        W1C
    } reg_kind_e;

    localparam int unsigned MAX_NREG   = 64;
    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    // Sticky event registers win over read-only when both mask bits are set.
    function automatic reg_kind_e kind_of(
        input int unsigned           idx,
        input logic [MAX_NREG-1:0]   ro_mask,
        input logic [MAX_NREG-1:0]   w1c_mask
    );
        logic [5:0] w_idx;
        w_idx = idx[5:0];
        if (w1c_mask[w_idx]) return W1C;
        if (ro_mask[w_idx])  return RO;
        return RW;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] new_v,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] r_v;
        r_v = old_v;
        for (int unsigned b = 0; b < MAX_BE_W; b++) begin
            if (be[b]) r_v[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r_v;
    endfunction

endpackage

// File: rtl/slave_io_rdpipe.sv
// Fixed-latency {valid, data} delay line for the Avalon read return path.
// A synchronous low reset_n flushes every in-flight entry.
module slave_io_rdpipe #(
    parameter int unsigned LAT = 2,
    parameter int unsigned W   = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [LAT-1:0] r_valid;
    logic [W-1:0]   r_data [LAT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < LAT; i++) r_data[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_data  = r_data[LAT-1];

endmodule

// File: rtl/slave_io_bank.sv
// Avalon-MM register bank of NREG x DATA_W RW / RO / W1C registers with strobes.
// Optional `SLAVE_IO_SNAPSHOT_EN: a read of address 0 snapshots all RO inputs.
module slave_io_bank
    import slave_io_pkg::*;
#(
    parameter int unsigned             NREG     = 16,
    parameter int unsigned             DATA_W   = 64,
    parameter int unsigned             RD_LAT   = 2,
    parameter logic [NREG-1:0]         RO_MASK  = '0,
    parameter logic [NREG-1:0]         W1C_MASK = '0,
    parameter logic [NREG*DATA_W-1:0]  RST_VAL  = '0,
    localparam int unsigned            ADDR_W   = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic                     avs_write,
    input  logic [DATA_W-1:0]        avs_writedata,
    input  logic [DATA_W/8-1:0]      avs_byteenable,
    input  logic                     avs_read,
    output logic [DATA_W-1:0]        avs_readdata,
    output logic                     avs_readdatavalid,
    output logic [NREG*DATA_W-1:0]   dataout,
    input  logic [NREG*DATA_W-1:0]   datain,
    output logic [NREG-1:0]          wr_strobe,
    output logic [NREG-1:0]          rd_strobe
);

    localparam int unsigned          BE_W   = DATA_W / 8;
    localparam logic [MAX_NREG-1:0]  RO_EXT = MAX_NREG'(RO_MASK);
    localparam logic [MAX_NREG-1:0]  W1_EXT = MAX_NREG'(W1C_MASK);

    logic [DATA_W-1:0]       r_regs [NREG];
    logic [NREG-1:0]         r_wr_strobe;
    logic [NREG-1:0]         r_rd_strobe;
    logic [NREG-1:0]         w_hit;
    logic [DATA_W-1:0]       w_lane_mask;
    logic [DATA_W-1:0]       w_rd_data;
    logic [DATA_W-1:0]       w_pipe_in;
    logic [NREG*DATA_W-1:0]  w_ro_src;
    logic                    w_unused;

    // Out-of-range addresses match no register, so they neither write nor strobe.
    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < NREG; i++) w_hit[i] = (avs_address == ADDR_W'(i));
    end

    always_comb begin
        w_lane_mask = '0;
        for (int unsigned b = 0; b < BE_W; b++) w_lane_mask[b*8 +: 8] = {8{avs_byteenable[b]}};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_strobe <= '0;
            r_rd_strobe <= '0;
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= (kind_of(i, RO_EXT, W1_EXT) == RW) ? RST_VAL[i*DATA_W +: DATA_W] : '0;
        end else begin
            r_wr_strobe <= avs_write ? w_hit : '0;
            r_rd_strobe <= avs_read  ? w_hit : '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                case (kind_of(i, RO_EXT, W1_EXT))
                    RW: if (avs_write && w_hit[i])
                        r_regs[i] <= DATA_W'(byte_merge(MAX_DATA_W'(r_regs[i]),
                                                        MAX_DATA_W'(avs_writedata),
                                                        MAX_BE_W'(avs_byteenable)));
                    // Set is ORed after the clear so a simultaneous event bit survives.
                    W1C: r_regs[i] <= (r_regs[i] & ~((avs_write && w_hit[i]) ?
                                                    (avs_writedata & w_lane_mask) : '0))
                                      | datain[i*DATA_W +: DATA_W];
                    default: r_regs[i] <= '0;
                endcase
            end
        end
    end

`ifdef SLAVE_IO_SNAPSHOT_EN
    logic [NREG*DATA_W-1:0] r_shadow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (avs_read && w_hit[0]) begin
            for (int unsigned i = 0; i < NREG; i++)
                if (kind_of(i, RO_EXT, W1_EXT) == RO)
                    r_shadow[i*DATA_W +: DATA_W] <= datain[i*DATA_W +: DATA_W];
        end
    end

    // Only an address-0 read sees live inputs: it is the one taking the snapshot.
    assign w_ro_src = w_hit[0] ? datain : r_shadow;
`else
    assign w_ro_src = datain;
`endif

    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (w_hit[i]) begin
                if (kind_of(i, RO_EXT, W1_EXT) == RO) w_rd_data = w_ro_src[i*DATA_W +: DATA_W];
                else                                  w_rd_data = r_regs[i];
            end
        end
    end

    always_comb begin
        dataout = '0;
        for (int unsigned i = 0; i < NREG; i++)
            if (kind_of(i, RO_EXT, W1_EXT) != RO) dataout[i*DATA_W +: DATA_W] = r_regs[i];
    end

    assign w_pipe_in = avs_read ? w_rd_data : '0;
    assign wr_strobe = r_wr_strobe;
    assign rd_strobe = r_rd_strobe;
    assign w_unused  = ^{datain, w_ro_src};

    slave_io_rdpipe #(
        .LAT (RD_LAT),
        .W   (DATA_W)
    ) u_rdpipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (avs_read),
        .i_data  (w_pipe_in),
        .o_valid (avs_readdatavalid),
        .o_data  (avs_readdata)
    );

endmodule

// File: tb/tb_slave_io_bank.sv
// Scoreboard bench for slave_io_bank: NREG=12, RO regs 1,2, W1C reg 7, RST reg3=0x1234.
// Honours SLAVE_IO_SNAPSHOT_EN for the RO read expectations.
module tb_slave_io_bank;

    localparam int unsigned NREG = 12;
    localparam int unsigned DW   = 64;
    localparam int unsigned LAT  = 2;
    localparam logic [NREG-1:0]    RO_M  = 12'h006;
    localparam logic [NREG-1:0]    W1C_M = 12'h080;
    localparam logic [NREG*DW-1:0] RST_V = {{((NREG-4)*DW){1'b0}}, 64'h1234, {(3*DW){1'b0}}};

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [3:0]           avs_address = '0;
    logic                 avs_write = 1'b0;
    logic [DW-1:0]        avs_writedata = '0;
    logic [DW/8-1:0]      avs_byteenable = '0;
    logic                 avs_read = 1'b0;
    logic [DW-1:0]        avs_readdata;
    logic                 avs_readdatavalid;
    logic [NREG*DW-1:0]   dataout;
    logic [NREG*DW-1:0]   datain = '0;
    logic [NREG-1:0]      wr_strobe;
    logic [NREG-1:0]      rd_strobe;

    slave_io_bank #(
        .NREG     (NREG),
        .DATA_W   (DW),
        .RD_LAT   (LAT),
        .RO_MASK  (RO_M),
        .W1C_MASK (W1C_M),
        .RST_VAL  (RST_V)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .dataout           (dataout),
        .datain            (datain),
        .wr_strobe         (wr_strobe),
        .rd_strobe         (rd_strobe)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } rd_t;

    rd_t           exp_q[$];
    rd_t           obs_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] mdl [NREG];

    always @(negedge clk) begin
        if (avs_readdatavalid === 1'b1) obs_q.push_back('{avs_readdata, cyc});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mdl();
        for (int i = 0; i < NREG; i++)
            mdl[i] = (!RO_M[i] && !W1C_M[i]) ? RST_V[i*DW +: DW] : '0;
    endtask

    // Leaves the caller one tick after the accepting edge, where wr_strobe is visible.
    task automatic do_write(input int unsigned a, input logic [DW-1:0] d, input logic [7:0] be);
        step();
        avs_address    = 4'(a);
        avs_write      = 1'b1;
        avs_read       = 1'b0;
        avs_writedata  = d;
        avs_byteenable = be;
        if (a < NREG && !RO_M[a] && !W1C_M[a])
            for (int b = 0; b < 8; b++) if (be[b]) mdl[a][b*8 +: 8] = d[b*8 +: 8];
        step();
        avs_write = 1'b0;
    endtask

    task automatic issue_read(input int unsigned a, input logic [DW-1:0] e);
        step();
        avs_address = 4'(a);
        avs_read    = 1'b1;
        avs_write   = 1'b0;
        exp_q.push_back('{e, cyc + LAT});
    endtask

    task automatic read_done();
        step();
        avs_read = 1'b0;
    endtask

    task automatic wait_obs();
        for (int t = 0; t < 60 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rd_t e, o;
        reset_n = 1'b0;
        repeat (3) step();
        total++;
        if (dataout !== RST_V) begin bad++; $display("FAIL rst_dataout: got %h required %h", dataout, RST_V); end
        total++;
        if (avs_readdatavalid !== 1'b0 || avs_readdata !== '0) begin
            bad++; $display("FAIL rst_rd: valid=%b data=%h required 0/0", avs_readdatavalid, avs_readdata);
        end
        total++;
        if (wr_strobe !== '0 || rd_strobe !== '0) begin
            bad++; $display("FAIL rst_strobe: wr=%h rd=%h required 0/0", wr_strobe, rd_strobe);
        end
        reset_n = 1'b1;
        init_mdl();
        // A read in flight when reset asserts must never return.
        step();
        avs_address = 4'd3;
        avs_read    = 1'b1;
        step();
        avs_read = 1'b0;
        reset_n  = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (5) step();
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL rst_flush: got %0d valids required 0", obs_q.size()); end
        obs_q.delete();
        for (int i = 0; i < NREG; i++) issue_read(i, (i == 3) ? 64'h1234 : 64'h0);
        read_done();
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL rst_readback: no valid, required %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL rst_readback: got %h @%0d required %h @%0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_byteenable();
        rd_t e, o;
        do_write(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        total++;
        if (wr_strobe !== 12'h020) begin bad++; $display("FAIL be_wr_strobe: got %h required 020", wr_strobe); end
        step();
        total++;
        if (wr_strobe !== 12'h000) begin bad++; $display("FAIL be_wr_strobe_end: got %h required 000", wr_strobe); end
        total++;
        if (dataout[5*DW +: DW] !== 64'h0000_0000_FFFF_FFFF) begin
            bad++; $display("FAIL be_dataout: got %h required 00000000ffffffff", dataout[5*DW +: DW]);
        end
        issue_read(5, 64'h0000_0000_FFFF_FFFF);
        read_done();
        total++;
        if (rd_strobe !== 12'h020) begin bad++; $display("FAIL be_rd_strobe: got %h required 020", rd_strobe); end
        // Read and write to the same register in one cycle: read sees the old value.
        step();
        avs_address    = 4'd5;
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        avs_writedata  = 64'h1111_2222_3333_4444;
        avs_byteenable = 8'hFF;
        mdl[5]         = 64'h1111_2222_3333_4444;
        exp_q.push_back('{64'h0000_0000_FFFF_FFFF, cyc + LAT});
        step();
        avs_read  = 1'b0;
        avs_write = 1'b0;
        issue_read(5, 64'h1111_2222_3333_4444);
        read_done();
        do_write(1, 64'hDEAD_BEEF, 8'hFF);
        total++;
        if (wr_strobe !== 12'h002) begin bad++; $display("FAIL ro_wr_strobe: got %h required 002", wr_strobe); end
        total++;
        if (dataout[1*DW +: DW] !== '0) begin bad++; $display("FAIL ro_dataout: got %h required 0", dataout[1*DW +: DW]); end
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL be_read: no valid, required %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL be_read: got %h @%0d required %h @%0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_w1c();
        rd_t e, o;
        step();
        datain[7*DW + 4] = 1'b1;
        step();
        datain[7*DW + 4] = 1'b0;
        total++;
        if (dataout[7*DW +: DW] !== 64'h10) begin bad++; $display("FAIL w1c_set: got %h required 10", dataout[7*DW +: DW]); end
        issue_read(7, 64'h10);
        issue_read(7, 64'h10);
        read_done();
        datain[7*DW + 4] = 1'b1;
        do_write(7, 64'h10, 8'hFF);
        issue_read(7, 64'h10);
        read_done();
        datain[7*DW + 4] = 1'b0;
        step();
        do_write(7, 64'h10, 8'hFE);
        issue_read(7, 64'h10);
        read_done();
        do_write(7, 64'h10, 8'hFF);
        step();
        total++;
        if (dataout[7*DW +: DW] !== '0) begin bad++; $display("FAIL w1c_clear: got %h required 0", dataout[7*DW +: DW]); end
        issue_read(7, 64'h0);
        read_done();
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL w1c_read: no valid, required %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL w1c_read: got %h @%0d required %h @%0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rd_t e, o;
        do_write(0, 64'hA0A0_0000_0000_00A0, 8'hFF);
        do_write(3, 64'h3333_0000_0000_0003, 8'hFF);
        do_write(4, 64'h4444_0000_0000_0004, 8'hFF);
        do_write(5, 64'h5555_0000_0000_0005, 8'hFF);
        do_write(6, 64'h6666_0000_0000_0006, 8'hFF);
        datain[1*DW +: DW] = 64'h11;
        datain[2*DW +: DW] = 64'h22;
        step();
        datain[7*DW +: DW] = 64'h5;
        step();
        datain[7*DW +: DW] = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1)      issue_read(i, 64'h11);
            else if (i == 2) issue_read(i, 64'h22);
            else if (i == 7) issue_read(i, 64'h5);
            else             issue_read(i, mdl[i]);
        end
        read_done();
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL b2b_read: no valid, required %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL b2b_read: got %h @%0d required %h @%0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        rd_t e, o;
        logic ok;
        do_write(13, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        total++;
        if (wr_strobe !== '0) begin bad++; $display("FAIL oor_wr_strobe: got %h required 000", wr_strobe); end
        step();
        ok = 1'b1;
        for (int i = 0; i < NREG; i++)
            if (!RO_M[i] && !W1C_M[i] && dataout[i*DW +: DW] !== mdl[i]) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL oor_dataout: got %h required RW slots unchanged", dataout); end
        issue_read(13, 64'h0);
        issue_read(12, 64'h0);
        issue_read(5, mdl[5]);
        read_done();
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL oor_read: no valid, required %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL oor_read: got %h @%0d required %h @%0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        rd_t e, o;
        logic [DW-1:0] exp_pre, exp_ro1;
`ifdef SLAVE_IO_SNAPSHOT_EN
        exp_pre = 64'h0;
        exp_ro1 = 64'hA;
`else
        exp_pre = 64'h77;
        exp_ro1 = 64'hB;
`endif
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        init_mdl();
        datain[1*DW +: DW] = 64'hA;
        datain[2*DW +: DW] = 64'h77;
        issue_read(2, exp_pre);
        issue_read(0, mdl[0]);
        step();
        datain[1*DW +: DW] = 64'hB;
        avs_address = 4'd1;
        exp_q.push_back('{exp_ro1, cyc + LAT});
        issue_read(2, 64'h77);
        read_done();
        wait_obs();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++; $display("FAIL snap_read: no valid, required %h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.cyc != e.cyc) begin
                    bad++; $display("FAIL snap_read: got %h @%0d required %h @%0d", o.data, o.cyc, e.data, e.cyc);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL extra_valid: got %0d stray valids required 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_byteenable();
        test_w1c();
        test_back_to_back();
        test_out_of_range();
        test_snapshot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
